// File: rtl/filter_peak_ctrl.sv
// Peak-detect controller for a shaped (trapezoidal) filter stream.
// Finds threshold crossings, tracks the pulse maximum, flags pile-up when
// a pulse stays above threshold too long, and hands events to a consumer
// through a single-entry buffer with a saturating drop counter.
module filter_peak_ctrl #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned TS_W      = 32,
    parameter int unsigned MAX_WIDTH = 64,
    parameter int unsigned DEAD_LEN  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] filter_data,
    input  logic              filter_valid,
    input  logic [DATA_W-1:0] threshold,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_amp,
    output logic [TS_W-1:0]   evt_time,
    output logic              evt_pileup,
    output logic              busy,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned WID_W  = $clog2(MAX_WIDTH + 1);
    localparam int unsigned DEAD_W = (DEAD_LEN < 1) ? 1 : $clog2(DEAD_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        TRACK = 2'd2,
        DEAD  = 2'd3
    } state_t;

    state_t                   state;
    logic [TS_W-1:0]          ts;
    logic signed [DATA_W-1:0] peak;
    logic [TS_W-1:0]          start_time;
    logic [WID_W-1:0]         width;
    logic [DEAD_W-1:0]        dead_cnt;

    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] thr_s;
    logic signed [DATA_W-1:0] peak_next;
    logic signed [DATA_W-1:0] evt_peak;
    logic [WID_W-1:0]         width_next;
    logic                     above;
    logic                     end_fall;
    logic                     end_pile;
    logic                     evt_write;

    // Signed compare helpers and end-of-pulse detection
    always_comb begin
        sample     = $signed(filter_data);
        thr_s      = $signed(threshold);
        above      = sample > thr_s;
        peak_next  = (sample > peak) ? sample : peak;
        width_next = width + WID_W'(1);
        end_fall   = enable && (state == TRACK) && filter_valid && !above;
        end_pile   = enable && (state == TRACK) && filter_valid && above
                     && (width_next == WID_W'(MAX_WIDTH));
        evt_write  = end_fall || end_pile;
        evt_peak   = end_pile ? peak_next : peak;
    end

    assign busy = (state == TRACK) || (state == DEAD);

    // Free-running sample timestamp, advances on every valid sample
    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= '0;
        end else if (filter_valid) begin
            ts <= ts + TS_W'(1);
        end
    end

    // Crossing / tracking / dead-time state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            peak       <= '0;
            start_time <= '0;
            width      <= '0;
            dead_cnt   <= '0;
        end else if (!enable) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: state <= ARM;
                ARM: begin
                    if (filter_valid && above) begin
                        state      <= TRACK;
                        peak       <= sample;
                        start_time <= ts;
                        width      <= WID_W'(1);
                    end
                end
                TRACK: begin
                    if (filter_valid) begin
                        if (evt_write) begin
                            state    <= DEAD;
                            dead_cnt <= '0;
                        end else begin
                            peak  <= peak_next;
                            width <= width_next;
                        end
                    end
                end
                DEAD: begin
                    if (filter_valid) begin
                        if (dead_cnt < DEAD_W'(DEAD_LEN)) begin
                            dead_cnt <= dead_cnt + DEAD_W'(1);
                        end else if (!above) begin
                            state <= ARM;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single-entry event buffer; a write while full is dropped unless the
    // consumer is taking the old entry on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid  <= 1'b0;
            evt_amp    <= '0;
            evt_time   <= '0;
            evt_pileup <= 1'b0;
            drop_cnt   <= '0;
        end else if (evt_write) begin
            if (evt_valid && !evt_ready) begin
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end else begin
                evt_valid  <= 1'b1;
                evt_amp    <= evt_peak;
                evt_time   <= start_time;
                evt_pileup <= end_pile;
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule
